wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_queue_if.sv | 29 ++
 rtl/wb_fifo_mem.sv | 37 +++
 rtl/wb_queue.sv | 145 ++++++++++++++
 tb/tb_wb_queue.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue.
//   REG_ADDR_W    : register-file address width
//   DEFAULT_WIDTH : default data width of a writeback entry
//   wb_entry_t    : one pending writeback {rd, data} at the default width
package wb_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]    rd;
    logic [DEFAULT_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Writeback request channel (valid/ready handshake).
//   in_valid : request valid          (master -> slave)
//   in_rd    : destination register   (master -> slave)
//   in_data  : writeback data         (master -> slave)
//   in_ready : queue can accept       (slave  -> master)
interface wb_queue_if import wb_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [WIDTH-1:0]      in_data;

  modport master (
    output in_valid,
    output in_rd,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_rd,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/wb_fifo_mem.sv
// Entry storage for the writeback queue: DEPTH x entry_t, one synchronous
// write port, one asynchronous read port, and every entry exposed so the
// parent can search pending writes for operand bypass.
//   clk     : clock
//   we      : write enable
//   waddr   : write index
//   wdata   : entry to write
//   raddr   : read index
//   rdata   : entry at raddr
//   entries : all stored entries
module wb_fifo_mem import wb_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned PtrW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PtrW-1:0] waddr,
  input  entry_t          wdata,
  input  logic [PtrW-1:0] raddr,
  output entry_t          rdata,
  output entry_t          entries [DEPTH]
);

  // No reset needed: the parent only ever looks at slots it has written.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata   = mem_q[raddr];
  assign entries = mem_q;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers register-file writes and drains them in order,
// one per cycle, whenever the register-file write port is free.
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   req            : request channel (wb_queue_if.slave)
//   wr_stall       : write port busy, hold the head entry
//   rd/busW/reg_wr : register-file write port
//   r_type         : destination select, always 1
//   count          : number of pending entries
//   rs_q/rs2_q     : read addresses to search for pending writes
//   hitA/hitB      : a pending entry matches rs_q / rs2_q
//   fwdA/fwdB      : data of the youngest matching entry
// Macro WB_QUEUE_BYPASS_EN enables the hit/forward search; without it those
// outputs are tied to 0.
module wb_queue import wb_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_queue_if.slave               req,
  input  logic                    wr_stall,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic [WIDTH-1:0]        busW,
  output logic                    reg_wr,
  output logic                    r_type,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [REG_ADDR_W-1:0]   rs_q,
  input  logic [REG_ADDR_W-1:0]   rs2_q,
  output logic                    hitA,
  output logic                    hitB,
  output logic [WIDTH-1:0]        fwdA,
  output logic [WIDTH-1:0]        fwdB
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      data;
  } entry_t;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  entry_t          wdata, head;
  entry_t          entries [DEPTH];

  // Writes to x0 are accepted but dropped.
  assign req.in_ready = (count_q != CntW'(DEPTH));
  assign push         = req.in_valid && req.in_ready && (req.in_rd != '0);
  assign pop          = (count_q != '0) && !wr_stall;

  assign wdata.rd   = req.in_rd;
  assign wdata.data = req.in_data;

  wb_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .PtrW    (PtrW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .waddr   (wr_ptr_q),
    .wdata   (wdata),
    .raddr   (rd_ptr_q),
    .rdata   (head),
    .entries (entries)
  );

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign reg_wr = pop;
  assign rd     = pop ? head.rd : '0;
  assign busW   = pop ? head.data : '0;
  assign r_type = 1'b1;
  assign count  = count_q;

`ifdef WB_QUEUE_BYPASS_EN
  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hitA = 1'b0;
    hitB = 1'b0;
    fwdA = '0;
    fwdB = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (entries[idx].rd != '0)) begin
        if (entries[idx].rd == rs_q) begin
          hitA = 1'b1;
          fwdA = entries[idx].data;
        end
        if (entries[idx].rd == rs2_q) begin
          hitB = 1'b1;
          fwdB = entries[idx].data;
        end
      end
    end
  end
`else
  logic unused_bypass;

  always_comb begin
    unused_bypass = ^{rs_q, rs2_q};
    for (int unsigned k = 0; k < DEPTH; k++) begin
      unused_bypass = unused_bypass ^ (^entries[k]);
    end
  end

  assign hitA = 1'b0;
  assign hitB = 1'b0;
  assign fwdA = '0;
  assign fwdB = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             wr_stall;
  logic [4:0]       rd;
  logic [WIDTH-1:0] busW;
  logic             reg_wr;
  logic             r_type;
  logic [2:0]       count;
  logic [4:0]       rs_q, rs2_q;
  logic             hitA, hitB;
  logic [WIDTH-1:0] fwdA, fwdB;

  wb_queue_if #(.WIDTH(WIDTH)) req_if ();

  wb_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_if),
    .wr_stall (wr_stall),
    .rd       (rd),
    .busW     (busW),
    .reg_wr   (reg_wr),
    .r_type   (r_type),
    .count    (count),
    .rs_q     (rs_q),
    .rs2_q    (rs2_q),
    .hitA     (hitA),
    .hitB     (hitB),
    .fwdA     (fwdA),
    .fwdB     (fwdB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [WIDTH-1:0] d);
    req_if.in_valid = 1'b1;
    req_if.in_rd    = r;
    req_if.in_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [WIDTH-1:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every write the DUT issues must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      check("reset_reg_wr", {63'd0, reg_wr}, 64'd0);
    end else if (reg_wr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual rd=%0d busW=%0h required no write", rd, busW);
      end else begin
        e = sb.pop_front();
        check("wb_rd", {59'd0, rd}, {59'd0, e.rd});
        check("wb_busW", {32'd0, busW}, {32'd0, e.data});
      end
    end else begin
      check("idle_rd", {59'd0, rd}, 64'd0);
      check("idle_busW", {32'd0, busW}, 64'd0);
    end
  end

  initial begin
    reset           = 1'b0;
    wr_stall        = 1'b0;
    req_if.in_valid = 1'b0;
    req_if.in_rd    = '0;
    req_if.in_data  = '0;
    rs_q            = 5'd5;
    rs2_q           = 5'd6;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, req_if.in_ready}, 64'd1);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_hitA", {63'd0, hitA}, 64'd0);
    check("rst_fwdA", {32'd0, fwdA}, 64'd0);
    check("r_type", {63'd0, r_type}, 64'd1);
    step();
    reset = 1'b1;

    // Single write, one cycle of latency
    drive(5'd3, 32'hDEADBEEF);
    expect_wr(5'd3, 32'hDEADBEEF);
    step();
    req_if.in_valid = 1'b0;
    @(negedge clk);
    check("t1_reg_wr", {63'd0, reg_wr}, 64'd1);
    step();
    @(negedge clk);
    check("t1_count", {61'd0, count}, 64'd0);
    check("t1_reg_wr_after", {63'd0, reg_wr}, 64'd0);

    // Fill under stall, fifth push held, then drain back to back
    step();
    wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(5'(i), 32'h100 + 32'(i));
      expect_wr(5'(i), 32'h100 + 32'(i));
      step();
    end
    drive(5'd5, 32'h105);
    @(negedge clk);
    check("t2_count_full", {61'd0, count}, 64'd4);
    check("t2_in_ready_full", {63'd0, req_if.in_ready}, 64'd0);
    step();
    step();
    @(negedge clk);
    check("t2_count_held", {61'd0, count}, 64'd4);
    step();
    wr_stall = 1'b0;
    expect_wr(5'd5, 32'h105);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_drain_reg_wr", {63'd0, reg_wr}, 64'd1);
      if (k == 0) check("t2_no_same_cycle_ready", {63'd0, req_if.in_ready}, 64'd0);
      step();
      if (k == 1) req_if.in_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_count_empty", {61'd0, count}, 64'd0);

    // Write to x0 is swallowed
    step();
    drive(5'd0, 32'h1234);
    @(negedge clk);
    check("t3_in_ready", {63'd0, req_if.in_ready}, 64'd1);
    step();
    req_if.in_valid = 1'b0;
    @(negedge clk);
    check("t3_count", {61'd0, count}, 64'd0);
    check("t3_reg_wr", {63'd0, reg_wr}, 64'd0);

    // Bypass search picks the youngest match
    step();
    wr_stall = 1'b1;
    drive(5'd5, 32'hA);
    expect_wr(5'd5, 32'hA);
    step();
    drive(5'd5, 32'hB);
    expect_wr(5'd5, 32'hB);
    step();
    req_if.in_valid = 1'b0;
    @(negedge clk);
`ifdef WB_QUEUE_BYPASS_EN
    check("t4_hitA", {63'd0, hitA}, 64'd1);
    check("t4_fwdA", {32'd0, fwdA}, 64'hB);
`else
    check("t4_hitA", {63'd0, hitA}, 64'd0);
    check("t4_fwdA", {32'd0, fwdA}, 64'd0);
`endif
    check("t4_hitB", {63'd0, hitB}, 64'd0);
    check("t4_fwdB", {32'd0, fwdB}, 64'd0);
    step();
    wr_stall = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t4_count_drained", {61'd0, count}, 64'd0);

    // Reset mid-operation discards pending entries
    step();
    wr_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(5'(i + 7), 32'h200 + 32'(i));
      expect_wr(5'(i + 7), 32'h200 + 32'(i));
      step();
    end
    req_if.in_valid = 1'b0;
    @(negedge clk);
    check("t5_count_pre", {61'd0, count}, 64'd3);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_count_rst", {61'd0, count}, 64'd0);
    check("t5_in_ready_rst", {63'd0, req_if.in_ready}, 64'd1);
    check("t5_reg_wr_rst", {63'd0, reg_wr}, 64'd0);
    step();
    reset    = 1'b1;
    wr_stall = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("t5_count_post", {61'd0, count}, 64'd0);

    // Steady push and pop across pointer wrap
    step();
    wr_stall = 1'b1;
    drive(5'd10, 32'h1010);
    expect_wr(5'd10, 32'h1010);
    step();
    drive(5'd11, 32'h1011);
    expect_wr(5'd11, 32'h1011);
    step();
    wr_stall = 1'b0;
    for (int j = 0; j < 10; j++) begin
      drive(5'(12 + j), 32'h1000 + 32'(12 + j));
      expect_wr(5'(12 + j), 32'h1000 + 32'(12 + j));
      @(negedge clk);
      check("t6_count_steady", {61'd0, count}, 64'd2);
      step();
    end
    req_if.in_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t6_count_drained", {61'd0, count}, 64'd0);

    step();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
